// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with saturating taken counters.
// Optional statistics counters are built only when BP_STATS_EN is defined.
module branch_predictor #(
  parameter int PC_W    = 32,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_taken,
  input  logic            upd_pred_taken,
  input  logic            inv,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispred
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1 << (CTR_W - 1));

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [PC_W-1:0]  tgt_q   [ENTRIES];
  logic [CTR_W-1:0] ctr_q   [ENTRIES];

  logic [IDX_W-1:0] if_idx, upd_idx;
  logic [TAG_W-1:0] if_tag, upd_tag;
  logic             upd_hit;
  logic [CTR_W-1:0] upd_ctr_cur, upd_ctr_next;

  assign if_idx  = if_pc[IDX_W+1:2];
  assign if_tag  = if_pc[PC_W-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[PC_W-1:IDX_W+2];

  // Kernel-space PCs (MSB set) never get a prediction.
  always_comb begin
    pred_taken  = 1'b0;
    pred_target = '0;
    if (valid_q[if_idx] && (tag_q[if_idx] == if_tag) &&
        ctr_q[if_idx][CTR_W-1] && !if_pc[PC_W-1]) begin
      pred_taken  = 1'b1;
      pred_target = tgt_q[if_idx];
    end
  end

  assign upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_ctr_cur = ctr_q[upd_idx];

  always_comb begin
    upd_ctr_next = upd_ctr_cur;
    if (upd_taken) begin
      if (upd_ctr_cur != CTR_MAX) upd_ctr_next = upd_ctr_cur + 1'b1;
    end else begin
      if (upd_ctr_cur != '0) upd_ctr_next = upd_ctr_cur - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= '0;
      end
    end else if (inv) begin
      // Only valid bits drop; stale tag/target/counter contents are kept.
      for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
    end else if (upd_valid && !upd_pc[PC_W-1]) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= upd_ctr_next;
        if (upd_taken) tgt_q[upd_idx] <= upd_target;
      end else if (upd_taken) begin
        valid_q[upd_idx] <= 1'b1;
        tag_q[upd_idx]   <= upd_tag;
        tgt_q[upd_idx]   <= upd_target;
        ctr_q[upd_idx]   <= CTR_INIT;
      end
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] branches_q, mispred_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branches_q <= '0;
      mispred_q  <= '0;
    end else if (upd_valid) begin
      if (branches_q != '1) branches_q <= branches_q + 32'd1;
      if ((upd_taken != upd_pred_taken) && (mispred_q != '1))
        mispred_q <= mispred_q + 32'd1;
    end
  end

  assign stat_branches = branches_q;
  assign stat_mispred  = mispred_q;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};
`else
  assign stat_branches = '0;
  assign stat_mispred  = '0;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0], upd_pred_taken};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor (default parameters).
// Statistics expectations follow whether BP_STATS_EN is defined.
module tb_branch_predictor;

  logic        clk;
  logic        reset;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        upd_pred_taken;
  logic        inv;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;

  int checks = 0;
  int errors = 0;

`ifdef BP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  branch_predictor dut (
    .clk            (clk),
    .reset          (reset),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_target     (upd_target),
    .upd_taken      (upd_taken),
    .upd_pred_taken (upd_pred_taken),
    .inv            (inv),
    .stat_branches  (stat_branches),
    .stat_mispred   (stat_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] ipc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic        upt;
    logic [31:0] utgt;
    logic        iv;
    logic        et;
    logic [31:0] etgt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [31:0] ipc, logic uv, logic [31:0] upc, logic ut,
                              logic upt, logic [31:0] utgt, logic iv, logic et,
                              logic [31:0] etgt);
    vec_t v;
    v.ipc = ipc; v.uv = uv; v.upc = upc; v.ut = ut; v.upt = upt;
    v.utgt = utgt; v.iv = iv; v.et = et; v.etgt = etgt;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_upd(logic uv, logic [31:0] upc, logic ut, logic upt,
                           logic [31:0] utgt, logic iv);
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_pred_taken = upt;
    upd_target = utgt; inv = iv;
  endtask

  initial begin
    int exp_br, exp_mp;

    // if_pc, upd_valid, upd_pc, upd_taken, upd_pred_taken, upd_target, inv, exp_taken, exp_target
    vecs.push_back(mk(32'h40, 0, 32'h0,  0, 0, 32'h0,   0, 0, 32'h0));
    vecs.push_back(mk(32'h40, 1, 32'h40, 1, 0, 32'h100, 0, 0, 32'h0));
    vecs.push_back(mk(32'h40, 0, 32'h0,  0, 0, 32'h0,   0, 1, 32'h100));
    vecs.push_back(mk(32'h40, 1, 32'h40, 0, 1, 32'h0,   0, 1, 32'h100));
    vecs.push_back(mk(32'h40, 1, 32'h40, 0, 1, 32'h0,   0, 0, 32'h0));
    vecs.push_back(mk(32'h40, 1, 32'h40, 0, 0, 32'h0,   0, 0, 32'h0));
    vecs.push_back(mk(32'h40, 1, 32'h40, 1, 0, 32'h200, 0, 0, 32'h0));
    vecs.push_back(mk(32'h40, 1, 32'h40, 1, 0, 32'h200, 0, 0, 32'h0));
    vecs.push_back(mk(32'h40, 1, 32'h40, 1, 1, 32'h200, 0, 1, 32'h200));
    vecs.push_back(mk(32'h40, 1, 32'h40, 1, 1, 32'h200, 0, 1, 32'h200));
    vecs.push_back(mk(32'h40, 1, 32'h40, 0, 1, 32'h999, 0, 1, 32'h200));
    vecs.push_back(mk(32'h43, 0, 32'h0,  0, 0, 32'h0,   0, 1, 32'h200));
    vecs.push_back(mk(32'h80, 1, 32'h80, 1, 0, 32'h300, 0, 0, 32'h0));
    vecs.push_back(mk(32'h40, 0, 32'h0,  0, 0, 32'h0,   0, 0, 32'h0));
    vecs.push_back(mk(32'h80, 0, 32'h0,  0, 0, 32'h0,   0, 1, 32'h300));
    vecs.push_back(mk(32'hC4, 1, 32'hC4, 0, 0, 32'h0,   0, 0, 32'h0));
    vecs.push_back(mk(32'hC4, 0, 32'h0,  0, 0, 32'h0,   0, 0, 32'h0));
    vecs.push_back(mk(32'h8000_0040, 1, 32'h8000_0040, 1, 0, 32'h500, 0, 0, 32'h0));
    vecs.push_back(mk(32'h80, 0, 32'h0,  0, 0, 32'h0,   0, 1, 32'h300));
    vecs.push_back(mk(32'h8000_0040, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0));
    vecs.push_back(mk(32'h44, 1, 32'h44, 1, 0, 32'h600, 0, 0, 32'h0));
    vecs.push_back(mk(32'h44, 0, 32'h0,  0, 0, 32'h0,   0, 1, 32'h600));
    vecs.push_back(mk(32'h44, 1, 32'h44, 1, 1, 32'h700, 1, 1, 32'h600));
    vecs.push_back(mk(32'h44, 0, 32'h0,  0, 0, 32'h0,   0, 0, 32'h0));
    vecs.push_back(mk(32'h80, 0, 32'h0,  0, 0, 32'h0,   0, 0, 32'h0));
    vecs.push_back(mk(32'h44, 1, 32'h44, 0, 0, 32'h0,   0, 0, 32'h0));
    vecs.push_back(mk(32'h44, 0, 32'h0,  0, 0, 32'h0,   0, 0, 32'h0));
    vecs.push_back(mk(32'h44, 1, 32'h44, 1, 0, 32'h800, 0, 0, 32'h0));
    vecs.push_back(mk(32'h44, 0, 32'h0,  0, 0, 32'h0,   0, 1, 32'h800));

    reset = 1'b0;
    if_pc = 32'h40;
    drive_upd(0, 32'h0, 0, 0, 32'h0, 0);
    #12;
    check("reset_pred_taken", {31'b0, pred_taken}, 32'h0);
    check("reset_pred_target", pred_target, 32'h0);
    check("reset_stat_branches", stat_branches, 32'h0);
    check("reset_stat_mispred", stat_mispred, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    exp_br = 0;
    exp_mp = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if_pc = vecs[i].ipc;
      drive_upd(vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].upt, vecs[i].utgt, vecs[i].iv);
      #1;
      check($sformatf("vec%0d_taken", i), {31'b0, pred_taken}, {31'b0, vecs[i].et});
      check($sformatf("vec%0d_target", i), pred_target, vecs[i].etgt);
      if (vecs[i].uv) begin
        exp_br++;
        if (vecs[i].ut != vecs[i].upt) exp_mp++;
      end
    end
    @(negedge clk);
    drive_upd(0, 32'h0, 0, 0, 32'h0, 0);
    #1;
    check("table_stat_branches", stat_branches, STATS ? 32'(exp_br) : 32'h0);
    check("table_stat_mispred", stat_mispred, STATS ? 32'(exp_mp) : 32'h0);

    // Reset in mid-operation drops the pending update and clears the table.
    @(negedge clk);
    if_pc = 32'h44;
    drive_upd(1, 32'h4C, 1, 0, 32'h900, 0);
    #1;
    check("pre_reset_taken", {31'b0, pred_taken}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_taken", {31'b0, pred_taken}, 32'h0);
    check("async_reset_target", pred_target, 32'h0);
    check("async_reset_branches", stat_branches, 32'h0);
    @(negedge clk);
    drive_upd(0, 32'h0, 0, 0, 32'h0, 0);
    @(negedge clk);
    reset = 1'b1;
    if_pc = 32'h4C;
    #1;
    check("aborted_upd_taken", {31'b0, pred_taken}, 32'h0);

    // Update presented across release is taken at the first edge with reset high.
    @(negedge clk);
    reset = 1'b0;
    drive_upd(1, 32'h40, 1, 0, 32'h100, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    if_pc = 32'h40;
    drive_upd(1, 32'h40, 1, 1, 32'h100, 0);
    #1;
    check("post_release_taken", {31'b0, pred_taken}, 32'h1);
    check("post_release_target", pred_target, 32'h100);
    @(negedge clk);
    drive_upd(1, 32'h40, 1, 1, 32'h100, 0);
    @(negedge clk);
    drive_upd(1, 32'h40, 0, 1, 32'h0, 0);
    @(negedge clk);
    drive_upd(1, 32'h40, 0, 0, 32'h0, 0);
    @(negedge clk);
    drive_upd(0, 32'h0, 0, 0, 32'h0, 0);
    #1;
    check("five_upd_branches", stat_branches, STATS ? 32'd5 : 32'd0);
    check("five_upd_mispred", stat_mispred, STATS ? 32'd2 : 32'd0);

    // Counter went 2->3->3->2->1, so no longer predicted taken.
    check("final_taken", {31'b0, pred_taken}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter PC_W, default 32, meaning program counter width in bits (>= 8).
REQ-002 Parameter ENTRIES, default 16, meaning number of direct-mapped table entries (power of two, >= 2); IDX_W = log2(ENTRIES).
REQ-003 Parameter CTR_W, default 2, meaning saturating counter width (1..4).
REQ-004 clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 if_pc  input  PC_W  fetch-stage PC to predict.
REQ-007 pred_taken  output  1  the fetch-stage branch is predicted taken.
REQ-008 pred_target  output  PC_W  predicted target; 0 when pred_taken=0.
REQ-009 upd_valid  input  1  one-cycle pulse: a resolved branch is reported this cycle.
REQ-010 upd_pc, upd_target  input  PC_W each  resolved branch PC and its actual target.
REQ-011 upd_taken, upd_pred_taken  input  1 each  actual outcome; prediction the branch was fetched with.
REQ-012 inv  input  1  one-cycle pulse that invalidates the whole table.
REQ-013 stat_branches, stat_mispred  output  32 each  statistics counters (see Configuration).

Function
REQ-014 Index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2]; pc[1:0] ignored.
REQ-015 Each entry holds valid, tag, target (PC_W) and a CTR_W-bit counter.
REQ-016 Lookup is combinational, zero latency: pred_taken=1 iff entry valid AND tag matches AND counter MSB=1, AND if_pc[PC_W-1]=0 (no prediction for kernel-space PCs).
REQ-017 Updates are registered and visible to lookup from the next cycle; a same-cycle lookup of the entry being updated returns the pre-update state (no bypass).
REQ-018 Update hit (valid, tag match): counter +1 if upd_taken, -1 otherwise, saturating at 0 and 2^CTR_W-1; target overwritten with upd_target only when upd_taken=1.
REQ-019 Update miss with upd_taken=1: entry replaced: valid=1, new tag, target=upd_target, counter=2^(CTR_W-1) (weakly taken).
REQ-020 Update miss with upd_taken=0: no table change.
REQ-021 Updates for upd_pc[PC_W-1]=1 are ignored (table unchanged; still counted in statistics).
REQ-022 inv asserted: all valid bits cleared at the next edge; inv takes priority over a simultaneous upd_valid, whose table update is discarded.
REQ-023 Tags, targets and counters are not cleared by inv; only valid bits.

Reset
REQ-024 While reset=0: all valid bits 0, all counters 0, statistics counters 0; pred_taken=0 and pred_target=0 for any if_pc.
REQ-025 Reset asserted mid-operation aborts any pending update; first update after release is accepted at the first rising edge with reset=1.

Configuration
REQ-026 Macro BP_STATS_EN defined: stat_branches increments on every upd_valid; stat_mispred increments when upd_valid and (upd_taken != upd_pred_taken); both saturate at 2^32-1; inv does not clear them.
REQ-027 Macro BP_STATS_EN undefined: no counter registers are built; stat_branches and stat_mispred are driven constant 0; ports remain present.

Verification
REQ-028 Reset, then if_pc=0x0000_0040 -> pred_taken=0, pred_target=0.
REQ-029 upd_valid, upd_pc=0x40, upd_taken=1, upd_target=0x100; next cycle if_pc=0x40 -> pred_taken=1, pred_target=0x100; same cycle as update -> pred_taken=0.
REQ-030 Two not-taken updates to 0x40 after allocation -> counter 2->1->0, pred_taken=0; four taken updates -> counter saturates at 3, pred_taken=1.
REQ-031 ENTRIES=16: allocate 0x40 (taken), then taken update to 0x80 (same index, different tag) -> lookup 0x40 gives pred_taken=0, lookup 0x80 gives target of second update.
REQ-032 inv and upd_valid (taken, 0x44) in the same cycle -> next cycle all lookups pred_taken=0; kernel PC 0x8000_0040 with upd_taken=1 -> never predicted.
REQ-033 With BP_STATS_EN: 5 updates, 2 with upd_taken != upd_pred_taken -> stat_branches=5, stat_mispred=2; without macro both read 0.
